result_writeback: RTL and testbench
===================================

// Module: result_writeback
// PURPOSE
//  Last datapath stage, directly downstream of the ALU. Takes the ALU result (R, op, D, carry) and steers it to one
//  of the four write ports: A, B, I, H. Also handles write-side I/O ports with full-flag backpressure.
//  Keeps one carry flag per hardware thread and returns it to the ALU c_in for the thread issuing add/sub.
//  Threads arrive in fixed round-robin order, one thread per cycle.
// PARAMETERS
//  WORD_WIDTH        36    data word width
//  OPCODE_WIDTH      4     ALU opcode width
//  D_OPERAND_WIDTH   12    destination address; top 2 bits select bank (00=A 01=B 10=I 11=H)
//  THREAD_COUNT      8     hardware threads, round-robin
//  THREAD_WIDTH      3     clog2(THREAD_COUNT)
//  THREAD_INIT       0     thread id whose result arrives on the first cycle after reset
//  IO_PORT_COUNT     4     output I/O ports per A and B bank; they occupy the top IO_PORT_COUNT bank-local addresses
//  CARRY_OP_0        4'h4  opcode that updates the carry (add)
//  CARRY_OP_1        4'h5  opcode that updates the carry (sub/borrow)
// PORTS
//  clock         in   1                  clock
//  reset         in   1                  synchronous, active-high
//  R             in   WORD_WIDTH         ALU result
//  op            in   OPCODE_WIDTH       ALU op_out
//  D             in   D_OPERAND_WIDTH    ALU D_out
//  c             in   1                  ALU c_out
//  annul         in   1                  flow-control cancel of the current result
//  io_full_A     in   IO_PORT_COUNT      A-side output port full flags
//  io_full_B     in   IO_PORT_COUNT      B-side output port full flags
//  carry_thread  in   THREAD_WIDTH       thread now issuing to ALU
//  carry_rd      out  1                  stored carry of carry_thread (registered)
//  wr_addr       out  D_OPERAND_WIDTH-2  bank-local write address, shared by all banks
//  wr_data       out  WORD_WIDTH         write data, shared by all banks
//  A_wren,B_wren,I_wren,H_wren  out 1    per-bank memory write enables
//  io_wren_A     out  IO_PORT_COUNT      one-hot I/O write pulse, A side
//  io_wren_B     out  IO_PORT_COUNT      one-hot I/O write pulse, B side
//  io_blocked    out  1                  write dropped because target port full
//  wb_thread     out  THREAD_WIDTH       thread id owning current outputs
// BEHAVIOUR
//  Latency
//  - Exactly 1 cycle from inputs to registered outputs. No stalls; one result accepted every cycle.
//  Thread counter
//  - Reset value THREAD_INIT.
//  - +1 per cycle, wraps THREAD_COUNT-1 -> 0.
//  - Tags the incoming result. Registered with outputs as wb_thread.
//  Decode and write
//  - bank = D[top 2 bits]; local = D[D_OPERAND_WIDTH-3:0]; IO hit when the bank is A or B and
//    local >= 2^(D_OPERAND_WIDTH-2) - IO_PORT_COUNT.
//  - port index = local - (2^(D_OPERAND_WIDTH-2) - IO_PORT_COUNT).
//  - A memory hit asserts that bank's wren for 1 cycle.
//  - An IO hit asserts no memory wren. It asserts io_wren_X[port] only if io_full_X[port]==0, sampled in the input cycle.
//    Otherwise io_blocked=1 for 1 cycle.
//  - annul=1: all wren, io_wren and io_blocked are 0. The carry is not updated. wr_addr/wr_data still update (don't-care).
//  - I and H banks have no I/O ports.
//  Carry file
//  - THREAD_COUNT x 1 bit. Updated with c for the tagged thread when op is CARRY_OP_0 or CARRY_OP_1,
//    annul==0 and io_blocked would be 0.
//  - carry_rd is the registered read of carry_thread.
//  - Same-cycle write and read of the same thread returns the new carry (write-first bypass).
//  Reset
//  - All wren/io_wren/io_blocked = 0; carry file all 0; carry_rd = 0; wr_addr/wr_data = 0; wb_thread = THREAD_INIT.
//  - A result presented in the reset cycle is dropped. Reset mid-stream drops any in-flight write and reloads the counter.
//  Invariants
//  - At most one of A/B/I/H_wren or one io_wren bit is high per cycle.
// TESTING
//  1 Reset, then D=12'h005, R=36'h123, op=0, annul=0 -> next cycle A_wren=1, wr_addr=10'h005, wr_data=36'h123,
//    wb_thread=0.
//  2 D=12'h7FF (B bank, top port 3), io_full_B=4'b0000 -> io_wren_B=4'b1000, B_wren=0.
//    Same with io_full_B[3]=1 -> io_wren_B=0, io_blocked=1.
//  3 Thread 2, op=CARRY_OP_0, c=1. Then carry_thread=2 in the same cycle -> carry_rd=1 next cycle (bypass).
//    Thread 3 still reads 0.
//  4 annul=1 with D=12'h805 (I bank), op=CARRY_OP_1, c=1 -> I_wren=0, carry of that thread unchanged.
//  5 Run 20 cycles with no reset -> wb_thread sequence 0..7,0..7,0..3.
//    Assert reset at cycle 10 -> wb_thread returns to 0 and no wren in the reset cycle.
//  6 Random D/R/op/annul/full for 10k cycles vs scoreboard model -> zero mismatches; never more than one enable high.

Source files
------------

// File: rtl/result_writeback.sv
// Final datapath stage: steers the ALU result to the A/B/I/H banks or the A/B output I/O ports,
// and keeps a per-thread carry flag that is fed back to the ALU.
module result_writeback #(
    parameter int unsigned WORD_WIDTH      = 36,
    parameter int unsigned OPCODE_WIDTH    = 4,
    parameter int unsigned D_OPERAND_WIDTH = 12,
    parameter int unsigned THREAD_COUNT    = 8,
    parameter int unsigned THREAD_WIDTH    = 3,
    parameter int unsigned THREAD_INIT     = 0,
    parameter int unsigned IO_PORT_COUNT   = 4,
    parameter logic [OPCODE_WIDTH-1:0] CARRY_OP_0 = 4'h4,
    parameter logic [OPCODE_WIDTH-1:0] CARRY_OP_1 = 4'h5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WORD_WIDTH-1:0]        R,
    input  logic [OPCODE_WIDTH-1:0]      op,
    input  logic [D_OPERAND_WIDTH-1:0]   D,
    input  logic                         c,
    input  logic                         annul,
    input  logic [IO_PORT_COUNT-1:0]     io_full_A,
    input  logic [IO_PORT_COUNT-1:0]     io_full_B,
    input  logic [THREAD_WIDTH-1:0]      carry_thread,
    output logic                         carry_rd,
    output logic [D_OPERAND_WIDTH-3:0]   wr_addr,
    output logic [WORD_WIDTH-1:0]        wr_data,
    output logic                         A_wren,
    output logic                         B_wren,
    output logic                         I_wren,
    output logic                         H_wren,
    output logic [IO_PORT_COUNT-1:0]     io_wren_A,
    output logic [IO_PORT_COUNT-1:0]     io_wren_B,
    output logic                         io_blocked,
    output logic [THREAD_WIDTH-1:0]      wb_thread
);

    localparam int unsigned LOCAL_WIDTH = D_OPERAND_WIDTH - 2;
    localparam int unsigned IO_BASE     = (1 << LOCAL_WIDTH) - IO_PORT_COUNT;
    localparam int unsigned PORT_WIDTH  = (IO_PORT_COUNT > 1) ? $clog2(IO_PORT_COUNT) : 1;

    localparam logic [1:0] BANK_A = 2'b00;
    localparam logic [1:0] BANK_B = 2'b01;
    localparam logic [1:0] BANK_I = 2'b10;
    localparam logic [1:0] BANK_H = 2'b11;

    logic [THREAD_WIDTH-1:0]  thread_cnt;
    logic [THREAD_COUNT-1:0]  carry_file;

    logic [1:0]               bank_c;
    logic [LOCAL_WIDTH-1:0]   local_c;
    logic [PORT_WIDTH-1:0]    port_c;
    logic                     io_zone_c;
    logic                     io_hit_c;
    logic                     port_full_c;
    logic                     blocked_c;
    logic                     carry_we_c;
    logic [3:0]               mem_wren_c;
    logic [IO_PORT_COUNT-1:0] io_wren_A_c;
    logic [IO_PORT_COUNT-1:0] io_wren_B_c;
    logic [THREAD_WIDTH-1:0]  thread_next_c;

    // Address decode, backpressure and enable generation for the incoming result
    always_comb begin
        bank_c      = D[D_OPERAND_WIDTH-1 -: 2];
        local_c     = D[LOCAL_WIDTH-1:0];
        io_zone_c   = (local_c >= LOCAL_WIDTH'(IO_BASE));
        port_c      = PORT_WIDTH'(local_c - LOCAL_WIDTH'(IO_BASE));
        io_hit_c    = io_zone_c && ((bank_c == BANK_A) || (bank_c == BANK_B));
        port_full_c = (bank_c == BANK_A) ? io_full_A[port_c] : io_full_B[port_c];
        blocked_c   = !annul && io_hit_c && port_full_c;
        carry_we_c  = !annul && !blocked_c && ((op == CARRY_OP_0) || (op == CARRY_OP_1));

        mem_wren_c  = 4'b0000;
        io_wren_A_c = '0;
        io_wren_B_c = '0;
        if (!annul) begin
            if (io_hit_c) begin
                if (!port_full_c) begin
                    if (bank_c == BANK_A) io_wren_A_c = IO_PORT_COUNT'(1) << port_c;
                    else                  io_wren_B_c = IO_PORT_COUNT'(1) << port_c;
                end
            end else begin
                case (bank_c)
                    BANK_A:  mem_wren_c = 4'b1000;
                    BANK_B:  mem_wren_c = 4'b0100;
                    BANK_I:  mem_wren_c = 4'b0010;
                    BANK_H:  mem_wren_c = 4'b0001;
                    default: mem_wren_c = 4'b0000;
                endcase
            end
        end

        thread_next_c = (thread_cnt == THREAD_WIDTH'(THREAD_COUNT - 1)) ?
                        '0 : thread_cnt + THREAD_WIDTH'(1);
    end

    // Output register stage and round-robin thread tag
    always_ff @(posedge clock) begin
        if (reset) begin
            thread_cnt <= THREAD_WIDTH'(THREAD_INIT);
            wb_thread  <= THREAD_WIDTH'(THREAD_INIT);
            wr_addr    <= '0;
            wr_data    <= '0;
            A_wren     <= 1'b0;
            B_wren     <= 1'b0;
            I_wren     <= 1'b0;
            H_wren     <= 1'b0;
            io_wren_A  <= '0;
            io_wren_B  <= '0;
            io_blocked <= 1'b0;
        end else begin
            thread_cnt <= thread_next_c;
            wb_thread  <= thread_cnt;
            wr_addr    <= local_c;
            wr_data    <= R;
            {A_wren, B_wren, I_wren, H_wren} <= mem_wren_c;
            io_wren_A  <= io_wren_A_c;
            io_wren_B  <= io_wren_B_c;
            io_blocked <= blocked_c;
        end
    end

    // Carry file with write-first read-back for the thread now issuing
    always_ff @(posedge clock) begin
        if (reset) begin
            carry_file <= '0;
            carry_rd   <= 1'b0;
        end else begin
            if (carry_we_c) carry_file[thread_cnt] <= c;
            if (carry_we_c && (carry_thread == thread_cnt)) carry_rd <= c;
            else                                            carry_rd <= carry_file[carry_thread];
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench for result_writeback: directed vector table, thread-sequence/reset
// sequences, and randomized traffic against a behavioural model.
module tb_result_writeback;

    logic        clock = 1'b0;
    logic        reset;
    logic [35:0] R;
    logic [3:0]  op;
    logic [11:0] D;
    logic        c;
    logic        annul;
    logic [3:0]  io_full_A;
    logic [3:0]  io_full_B;
    logic [2:0]  carry_thread;
    logic        carry_rd;
    logic [9:0]  wr_addr;
    logic [35:0] wr_data;
    logic        A_wren, B_wren, I_wren, H_wren;
    logic [3:0]  io_wren_A;
    logic [3:0]  io_wren_B;
    logic        io_blocked;
    logic [2:0]  wb_thread;

    always #5 clock = ~clock;

    result_writeback dut (
        .clock(clock), .reset(reset), .R(R), .op(op), .D(D), .c(c), .annul(annul),
        .io_full_A(io_full_A), .io_full_B(io_full_B), .carry_thread(carry_thread),
        .carry_rd(carry_rd), .wr_addr(wr_addr), .wr_data(wr_data),
        .A_wren(A_wren), .B_wren(B_wren), .I_wren(I_wren), .H_wren(H_wren),
        .io_wren_A(io_wren_A), .io_wren_B(io_wren_B), .io_blocked(io_blocked),
        .wb_thread(wb_thread)
    );

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        rst;
        logic [11:0] d;
        logic [35:0] r;
        logic [3:0]  op;
        logic        c;
        logic        an;
        logic [3:0]  fa;
        logic [3:0]  fb;
        logic [2:0]  ct;
        logic [3:0]  wren;   // {A,B,I,H}
        logic [3:0]  iowa;
        logic [3:0]  iowb;
        logic        blk;
        logic        crd;
        logic [2:0]  wb;
        logic [9:0]  addr;
        logic [35:0] data;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic apply(input logic rst_i, input logic [11:0] d_i, input logic [35:0] r_i,
                         input logic [3:0] op_i, input logic c_i, input logic an_i,
                         input logic [3:0] fa_i, input logic [3:0] fb_i, input logic [2:0] ct_i);
        reset = rst_i; D = d_i; R = r_i; op = op_i; c = c_i; annul = an_i;
        io_full_A = fa_i; io_full_B = fb_i; carry_thread = ct_i;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [16:0] ctrl_now();
        return {A_wren, B_wren, I_wren, H_wren, io_wren_A, io_wren_B, io_blocked, carry_rd, wb_thread};
    endfunction

    // Behavioural model state
    int thr_m;
    bit carry_m[8];

    initial begin
        vecs[0]  = '{1'b1, 12'h005, 36'h999, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 10'h000, 36'h0};
        vecs[1]  = '{1'b0, 12'h005, 36'h123, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 4'b1000, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 10'h005, 36'h123};
        vecs[2]  = '{1'b0, 12'h7FF, 36'h456, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 4'b0000, 4'h0, 4'h8, 1'b0, 1'b0, 3'd1, 10'h3FF, 36'h456};
        vecs[3]  = '{1'b0, 12'h100, 36'h777, 4'h4, 1'b1, 1'b0, 4'h0, 4'h0, 3'd2, 4'b1000, 4'h0, 4'h0, 1'b0, 1'b1, 3'd2, 10'h100, 36'h777};
        vecs[4]  = '{1'b0, 12'h7FF, 36'h888, 4'h4, 1'b1, 1'b0, 4'h0, 4'h8, 3'd3, 4'b0000, 4'h0, 4'h0, 1'b1, 1'b0, 3'd3, 10'h3FF, 36'h888};
        vecs[5]  = '{1'b0, 12'h805, 36'hAAA, 4'h5, 1'b1, 1'b1, 4'h0, 4'h0, 3'd2, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b1, 3'd4, 10'h005, 36'hAAA};
        vecs[6]  = '{1'b0, 12'h805, 36'hBBB, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd4, 4'b0010, 4'h0, 4'h0, 1'b0, 1'b0, 3'd5, 10'h005, 36'hBBB};
        vecs[7]  = '{1'b0, 12'hC12, 36'hCCC, 4'h5, 1'b0, 1'b0, 4'h0, 4'h0, 3'd2, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b1, 3'd6, 10'h012, 36'hCCC};
        vecs[8]  = '{1'b0, 12'h3FC, 36'hDDD, 4'h5, 1'b1, 1'b0, 4'hE, 4'h0, 3'd7, 4'b0000, 4'h1, 4'h0, 1'b0, 1'b1, 3'd7, 10'h3FC, 36'hDDD};
        vecs[9]  = '{1'b0, 12'h3FB, 36'hEEE, 4'h0, 1'b0, 1'b0, 4'hF, 4'h0, 3'd7, 4'b1000, 4'h0, 4'h0, 1'b0, 1'b1, 3'd0, 10'h3FB, 36'hEEE};
        vecs[10] = '{1'b0, 12'hFFF, 36'hFFF, 4'h0, 1'b0, 1'b0, 4'hF, 4'hF, 3'd0, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0, 3'd1, 10'h3FF, 36'hFFF};
        vecs[11] = '{1'b0, 12'hBFF, 36'h111, 4'h4, 1'b0, 1'b0, 4'h0, 4'h0, 3'd2, 4'b0010, 4'h0, 4'h0, 1'b0, 1'b0, 3'd2, 10'h3FF, 36'h111};
        vecs[12] = '{1'b1, 12'h005, 36'h222, 4'h4, 1'b1, 1'b0, 4'h0, 4'h0, 3'd2, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 10'h000, 36'h0};
        vecs[13] = '{1'b0, 12'h005, 36'h333, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd7, 4'b1000, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 10'h005, 36'h333};

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].rst, vecs[i].d, vecs[i].r, vecs[i].op, vecs[i].c, vecs[i].an,
                  vecs[i].fa, vecs[i].fb, vecs[i].ct);
            check($sformatf("vec%0d_ctrl", i), 64'(ctrl_now()),
                  64'({vecs[i].wren, vecs[i].iowa, vecs[i].iowb, vecs[i].blk, vecs[i].crd, vecs[i].wb}));
            check($sformatf("vec%0d_addr", i), 64'(wr_addr), 64'(vecs[i].addr));
            check($sformatf("vec%0d_data", i), 64'(wr_data), 64'(vecs[i].data));
        end

        // Round-robin thread tag over 20 cycles after reset
        apply(1'b1, 12'h005, 36'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0);
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 12'h005, 36'(i), 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0);
            check($sformatf("rr_wb%0d", i), 64'(wb_thread), 64'(i % 8));
        end

        // Mid-stream reset drops the in-flight write and reloads the counter
        for (int i = 0; i < 10; i++)
            apply(1'b0, 12'h405, 36'h5A5, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0);
        apply(1'b1, 12'h405, 36'h5A5, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0);
        check("midreset_ctrl", 64'(ctrl_now()), 64'(17'd0));
        apply(1'b0, 12'h405, 36'h5A5, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0);
        check("midreset_first", 64'({B_wren, wb_thread}), 64'({1'b1, 3'd0}));

        // Randomized traffic against the behavioural model
        apply(1'b1, 12'h0, 36'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0);
        thr_m = 0;
        foreach (carry_m[k]) carry_m[k] = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            logic        rst_r, c_r, an_r;
            logic [11:0] d_r;
            logic [35:0] r_r;
            logic [3:0]  op_r, fa_r, fb_r;
            logic [2:0]  ct_r;
            int          bank, loc, port;
            logic [3:0]  wren_e, iowa_e, iowb_e;
            logic        blk_e, full;
            logic [16:0] exp_ctrl;
            logic [9:0]  exp_addr;
            logic [35:0] exp_data;

            rst_r = ($urandom_range(199) == 0);
            if ($urandom_range(3) == 0)
                d_r = 12'(($urandom_range(3) << 10) + 1020 + $urandom_range(3));
            else
                d_r = 12'($urandom);
            r_r  = {4'($urandom), 32'($urandom)};
            op_r = 4'($urandom_range(7));
            c_r  = 1'($urandom);
            an_r = ($urandom_range(7) == 0);
            fa_r = 4'($urandom);
            fb_r = 4'($urandom);
            ct_r = 3'($urandom);

            wren_e = 4'b0; iowa_e = 4'b0; iowb_e = 4'b0; blk_e = 1'b0;
            if (rst_r) begin
                thr_m = 0;
                foreach (carry_m[k]) carry_m[k] = 1'b0;
                exp_ctrl = 17'd0;
                exp_addr = 10'd0;
                exp_data = 36'd0;
            end else begin
                bank = int'(d_r) / 1024;
                loc  = int'(d_r) % 1024;
                port = loc - 1020;
                full = 1'b0;
                if (bank < 2 && loc >= 1020) full = (bank == 0) ? fa_r[port] : fb_r[port];
                if (!an_r) begin
                    if (bank < 2 && loc >= 1020) begin
                        if (full)           blk_e  = 1'b1;
                        else if (bank == 0) iowa_e = 4'(1 << port);
                        else                iowb_e = 4'(1 << port);
                    end else begin
                        wren_e = 4'(8 >> bank);
                    end
                    if (!blk_e && (op_r == 4'h4 || op_r == 4'h5)) carry_m[thr_m] = c_r;
                end
                exp_ctrl = {wren_e, iowa_e, iowb_e, blk_e, carry_m[ct_r], 3'(thr_m)};
                exp_addr = 10'(loc);
                exp_data = r_r;
                thr_m = (thr_m + 1) % 8;
            end

            apply(rst_r, d_r, r_r, op_r, c_r, an_r, fa_r, fb_r, ct_r);
            check($sformatf("rand%0d_ctrl", n), 64'(ctrl_now()), 64'(exp_ctrl));
            check($sformatf("rand%0d_addr", n), 64'(wr_addr), 64'(exp_addr));
            check($sformatf("rand%0d_data", n), 64'(wr_data), 64'(exp_data));
            check($sformatf("rand%0d_onehot", n),
                  64'($countones({A_wren, B_wren, I_wren, H_wren, io_wren_A, io_wren_B}) <= 1), 64'(1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
